pearson_decipher: RTL and testbench
===================================

PEARSON_DECIPHER -- requirements
Module: pearson_decipher

Interface
REQ-001 The block SHALL have no parameters; the table is fixed at 256 x 8 bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 write_enable  input  1  key-table write request.
REQ-005 write_ready  output  1  block accepts a key write this cycle.
REQ-006 idx_in  input  8  forward-table index of the key entry.
REQ-007 key_byte_in  input  8  forward-table value T[idx_in].
REQ-008 init_hash_enable  input  1  load the chain state from seed_in.
REQ-009 init_hash_ready  output  1  block accepts a chain-state load this cycle.
REQ-010 seed_in  input  8  initial chain state (the h0 used by the encoder).
REQ-011 decipher_enable  input  1  decipher request for cipher_in.
REQ-012 decipher_ready  output  1  block accepts a decipher request this cycle.
REQ-013 cipher_in  input  8  next Pearson chain value h(n).
REQ-014 data_out  output  8  recovered plaintext byte.
REQ-015 data_valid  output  1  one-cycle pulse; data_out is valid.
REQ-016 key_error  output  1  sticky flag; the loaded key is not a permutation.
REQ-017 loaded_count  output  9  number of distinct key bytes written, 0..256.

Function
REQ-018 Purpose: invert the forward chain h(n) = T[h(n-1) XOR d(n)], recovering d(n) = Tinv[h(n)] XOR h(n-1).
REQ-019 FSM states: LOAD, READY, ERROR.
REQ-020 write_ready SHALL be 1 only in LOAD; init_hash_ready and decipher_ready SHALL be 1 only in READY.
REQ-021 A write is accepted when write_enable and write_ready are both 1: inv[key_byte_in] <= idx_in, and seen[key_byte_in] <= 1.
REQ-022 If seen[key_byte_in] is already 1 on an accepted write, the block SHALL set key_error <= 1, go to ERROR, and leave loaded_count unchanged.
REQ-023 Otherwise an accepted write SHALL increment loaded_count by 1.
REQ-024 The write that makes loaded_count 256 SHALL move the FSM to READY on the same edge.
REQ-025 In READY, write_enable SHALL be ignored; re-keying requires reset.
REQ-026 ERROR SHALL be left only by reset; in ERROR all ready outputs are 0 and all requests are ignored.
REQ-027 An accepted init (init_hash_enable and init_hash_ready both 1) SHALL set h_prev <= seed_in; it produces no data_valid.
REQ-028 An accepted decipher SHALL, on that edge, set data_out <= inv[cipher_in] XOR h_prev and h_prev <= cipher_in, and SHALL pulse data_valid for the following cycle.
REQ-029 Latency SHALL be 1 cycle from acceptance to data_valid; the block SHALL accept back-to-back deciphers at full rate (one per cycle).
REQ-030 If init and decipher are both asserted in the same cycle, init SHALL win and the decipher is dropped (no data_valid).
REQ-031 Deciphering without a prior init SHALL use h_prev = 0.
REQ-032 data_out SHALL hold its last value while data_valid is 0.
REQ-033 idx_in is not checked for uniqueness; only the uniqueness of key_byte_in is enforced.

Reset
REQ-034 When reset is asserted, the block SHALL, on that edge, set: state = LOAD, seen = all zero, loaded_count = 0, key_error = 0, h_prev = 0, data_out = 0, data_valid = 0.
REQ-035 The inv array SHALL NOT be reset; it is valid only after a complete load.
REQ-036 Reset SHALL take priority over all concurrent requests, including reset asserted mid-load or mid-stream.
REQ-037 In the first cycle after reset: write_ready = 1, init_hash_ready = 0, decipher_ready = 0.

Verification
REQ-038 Full load: write T[i] = 255-i for i = 0..255 -> loaded_count = 256, state READY, key_error = 0, write_ready = 0, decipher_ready = 1.
REQ-039 Chain decipher: after the full load, init with seed 0, then decipher 0xF5 and then 0x00 on consecutive cycles -> data_valid on two consecutive cycles, with data_out = 0x0A then 0x0A.
REQ-040 Duplicate key: after reset, write (0, 0x07) then (1, 0x07) -> key_error = 1, loaded_count = 1, all ready outputs = 0, and subsequent requests produce no data_valid.
REQ-041 Reset mid-load: after 100 writes, assert reset -> loaded_count = 0, write_ready = 1, key_error = 0; a full reload then reaches READY.
REQ-042 Simultaneous requests: in READY, assert init (seed 0x33) and decipher together -> no data_valid, h_prev = 0x33; a following decipher of 0xF5 gives data_out = 0x0A XOR 0x33 = 0x39.
REQ-043 Round trip: drive the PearsonHash encoder with the same key and seed over 256 random bytes, and feed its cipher_out to this block -> data_out equals the original bytes in order.

Source files
------------

// File: rtl/pearson_decipher.sv
// Inverse Pearson chain: rebuilds the inverse key table from forward-table writes
// and recovers plaintext as d(n) = Tinv[h(n)] ^ h(n-1).
module pearson_decipher (
    input  logic       clk,
    input  logic       reset,
    input  logic       write_enable,
    output logic       write_ready,
    input  logic [7:0] idx_in,
    input  logic [7:0] key_byte_in,
    input  logic       init_hash_enable,
    output logic       init_hash_ready,
    input  logic [7:0] seed_in,
    input  logic       decipher_enable,
    output logic       decipher_ready,
    input  logic [7:0] cipher_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       key_error,
    output logic [8:0] loaded_count
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_READY = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t       r_state;
    logic [255:0] r_seen;
    logic [7:0]   r_inv [0:255];
    logic [8:0]   r_loaded_count;
    logic         r_key_error;
    logic [7:0]   r_h_prev;
    logic [7:0]   r_data_out;
    logic         r_data_valid;

    logic         w_write_acc;

    assign write_ready     = (r_state == S_LOAD);
    assign init_hash_ready = (r_state == S_READY);
    assign decipher_ready  = (r_state == S_READY);
    assign w_write_acc     = write_enable && (r_state == S_LOAD);

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign key_error    = r_key_error;
    assign loaded_count = r_loaded_count;

    // Inverse table is deliberately unreset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_write_acc && !reset) begin
            r_inv[key_byte_in] <= idx_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_LOAD;
            r_seen         <= '0;
            r_loaded_count <= 9'd0;
            r_key_error    <= 1'b0;
            r_h_prev       <= 8'd0;
            r_data_out     <= 8'd0;
            r_data_valid   <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (write_enable) begin
                        if (r_seen[key_byte_in]) begin
                            r_key_error <= 1'b1;
                            r_state     <= S_ERROR;
                        end else begin
                            r_seen[key_byte_in] <= 1'b1;
                            r_loaded_count      <= r_loaded_count + 9'd1;
                            if (r_loaded_count == 9'd255) begin
                                r_state <= S_READY;
                            end
                        end
                    end
                end
                S_READY: begin
                    // A concurrent init takes precedence and swallows the decipher.
                    if (init_hash_enable) begin
                        r_h_prev <= seed_in;
                    end else if (decipher_enable) begin
                        r_data_out   <= r_inv[cipher_in] ^ r_h_prev;
                        r_h_prev     <= cipher_in;
                        r_data_valid <= 1'b1;
                    end
                end
                S_ERROR: begin
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pearson_decipher.sv
// Directed bench for pearson_decipher; a queue scoreboard holds plaintext expected
// from each accepted decipher and a negedge monitor consumes it.
module tb_pearson_decipher;

    logic       clk;
    logic       reset;
    logic       write_enable;
    logic       write_ready;
    logic [7:0] idx_in;
    logic [7:0] key_byte_in;
    logic       init_hash_enable;
    logic       init_hash_ready;
    logic [7:0] seed_in;
    logic       decipher_enable;
    logic       decipher_ready;
    logic [7:0] cipher_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       key_error;
    logic [8:0] loaded_count;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] perm[256];

    pearson_decipher dut (
        .clk              (clk),
        .reset            (reset),
        .write_enable     (write_enable),
        .write_ready      (write_ready),
        .idx_in           (idx_in),
        .key_byte_in      (key_byte_in),
        .init_hash_enable (init_hash_enable),
        .init_hash_ready  (init_hash_ready),
        .seed_in          (seed_in),
        .decipher_enable  (decipher_enable),
        .decipher_ready   (decipher_ready),
        .cipher_in        (cipher_in),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .key_error        (key_error),
        .loaded_count     (loaded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (data_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 16'(data_valid), 16'd0);
            end else begin
                chk("data_out", 16'(data_out), 16'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic write_key(input logic [7:0] idx, input logic [7:0] key);
        write_enable = 1'b1;
        idx_in       = idx;
        key_byte_in  = key;
        step();
        write_enable = 1'b0;
    endtask

    task automatic do_init(input logic [7:0] seed);
        init_hash_enable = 1'b1;
        seed_in          = seed;
        step();
        init_hash_enable = 1'b0;
    endtask

    task automatic do_decipher(input logic [7:0] c, input logic [7:0] expected, input bit expect_out);
        decipher_enable = 1'b1;
        cipher_in       = c;
        if (expect_out) exp_q.push_back(expected);
        step();
        decipher_enable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] h;
        logic [7:0] d;
        logic [7:0] seed;
        logic [7:0] tmp;
        int         j;

        reset = 1'b1; write_enable = 1'b0; idx_in = 8'd0; key_byte_in = 8'd0;
        init_hash_enable = 1'b0; seed_in = 8'd0; decipher_enable = 1'b0; cipher_in = 8'd0;
        step();
        do_reset();

        chk("rst_write_ready", 16'(write_ready), 16'd1);
        chk("rst_init_ready", 16'(init_hash_ready), 16'd0);
        chk("rst_dec_ready", 16'(decipher_ready), 16'd0);
        chk("rst_count", 16'(loaded_count), 16'd0);
        chk("rst_key_error", 16'(key_error), 16'd0);
        chk("rst_data_out", 16'(data_out), 16'd0);
        chk("rst_data_valid", 16'(data_valid), 16'd0);

        // Full load with T[i] = 255 - i, so Tinv[v] = 255 - v.
        for (int i = 0; i < 256; i++) write_key(8'(i), 8'(255 - i));
        chk("load_count", 16'(loaded_count), 16'd256);
        chk("load_key_error", 16'(key_error), 16'd0);
        chk("load_write_ready", 16'(write_ready), 16'd0);
        chk("load_dec_ready", 16'(decipher_ready), 16'd1);
        chk("load_init_ready", 16'(init_hash_ready), 16'd1);

        // No init yet: h_prev = 0, so 0x10 -> 0xEF.
        do_decipher(8'h10, 8'hEF, 1'b1);
        do_init(8'h00);
        do_decipher(8'hF5, 8'h0A, 1'b1);
        do_decipher(8'h00, 8'h0A, 1'b1);
        step();
        step();
        chk("hold_data_out", 16'(data_out), 16'h000A);
        chk("hold_data_valid", 16'(data_valid), 16'd0);

        write_key(8'h00, 8'h00);
        chk("ready_ignores_write", 16'(loaded_count), 16'd256);
        chk("ready_no_error", 16'(key_error), 16'd0);

        // Init and decipher together: init wins, nothing emitted.
        init_hash_enable = 1'b1; seed_in = 8'h33;
        decipher_enable = 1'b1; cipher_in = 8'h77;
        step();
        init_hash_enable = 1'b0; decipher_enable = 1'b0;
        do_decipher(8'hF5, 8'h39, 1'b1);
        step();

        // Duplicate key byte.
        do_reset();
        write_key(8'd0, 8'h07);
        write_key(8'd1, 8'h07);
        chk("dup_key_error", 16'(key_error), 16'd1);
        chk("dup_count", 16'(loaded_count), 16'd1);
        chk("dup_write_ready", 16'(write_ready), 16'd0);
        chk("dup_init_ready", 16'(init_hash_ready), 16'd0);
        chk("dup_dec_ready", 16'(decipher_ready), 16'd0);
        do_init(8'h11);
        do_decipher(8'h22, 8'h00, 1'b0);
        do_decipher(8'h23, 8'h00, 1'b0);
        write_key(8'd2, 8'h08);
        chk("err_count_frozen", 16'(loaded_count), 16'd1);
        chk("err_sticky", 16'(key_error), 16'd1);

        // Random permutation key, reset after 100 writes, then a full reload.
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        do_reset();
        for (int i = 0; i < 100; i++) write_key(8'(i), perm[i]);
        chk("mid_count_100", 16'(loaded_count), 16'd100);
        do_reset();
        chk("mid_rst_count", 16'(loaded_count), 16'd0);
        chk("mid_rst_write_ready", 16'(write_ready), 16'd1);
        chk("mid_rst_key_error", 16'(key_error), 16'd0);
        for (int i = 0; i < 256; i++) write_key(8'(i), perm[i]);
        chk("reload_count", 16'(loaded_count), 16'd256);
        chk("reload_dec_ready", 16'(decipher_ready), 16'd1);

        // Round trip through an encoder model h = T[h ^ d].
        seed = 8'($urandom);
        do_init(seed);
        h = seed;
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom);
            h = perm[h ^ d];
            do_decipher(h, d, 1'b1);
        end

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) step();
        chk("queue_drained", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
